// File: rtl/ex_fsm_stim_gen.sv
// ex_fsm_stim_gen
// Generates a programmed level pattern on A for driving ex_fsm:
// an idle-low lead-in, then a train of high pulses separated by low gaps.
// Every segment length is exact to the clock cycle.
//
// Ports:
//   sclk      system clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   start     run request, sampled only while idle
//   lead_len  low cycles before the first pulse
//   high_len  high cycles per pulse (0 behaves as 1)
//   low_len   low cycles between pulses (0 behaves as 1)
//   pulses    number of high pulses (0 = empty request)
//   A         generated level (flop output)
//   busy      high while a sequence is running (flop output)
//   done      one-cycle completion strobe (flop output)
module ex_fsm_stim_gen #(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 8
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   lead_len,
  input  logic [CNT_W-1:0]   high_len,
  input  logic [CNT_W-1:0]   low_len,
  input  logic [PULSE_W-1:0] pulses,
  output logic               A,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, LEAD, HIGH, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;      // cycles left in the current segment, minus one
  logic [CNT_W-1:0]   high_m1;  // latched high length minus one
  logic [CNT_W-1:0]   low_m1;   // latched low length minus one
  logic [PULSE_W-1:0] rem;      // pulses still to be emitted, including the current one

  // Segment reload values computed from the live inputs; a zero length is
  // treated as one cycle, so the reload value clamps at zero.
  logic [CNT_W-1:0] high_m1_in;
  logic [CNT_W-1:0] low_m1_in;

  assign high_m1_in = (high_len == '0) ? '0 : high_len - CNT_W'(1);
  assign low_m1_in  = (low_len  == '0) ? '0 : low_len  - CNT_W'(1);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      high_m1 <= '0;
      low_m1  <= '0;
      rem     <= '0;
      A       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            high_m1 <= high_m1_in;
            low_m1  <= low_m1_in;
            rem     <= pulses;
            busy    <= 1'b1;
            if (pulses == '0) begin
              // Empty request: one busy cycle spent in LEAD with a zero
              // count, then completion on the next edge with A held low.
              state <= LEAD;
              cnt   <= '0;
            end else if (lead_len == '0) begin
              state <= HIGH;
              A     <= 1'b1;
              cnt   <= high_m1_in;
            end else begin
              state <= LEAD;
              cnt   <= lead_len - CNT_W'(1);
            end
          end
        end

        LEAD: begin
          if (cnt == '0) begin
            if (rem == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= HIGH;
              A     <= 1'b1;
              cnt   <= high_m1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        HIGH: begin
          if (cnt == '0) begin
            A <= 1'b0;
            if (rem > PULSE_W'(1)) begin
              state <= GAP;
              cnt   <= low_m1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              rem   <= '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            state <= HIGH;
            A     <= 1'b1;
            cnt   <= high_m1;
            if (rem != '0) rem <= rem - PULSE_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          A     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_fsm_stim_gen.sv
// Self-checking bench for ex_fsm_stim_gen. Expected waveforms come from the
// closed-form timing rules (pulse k rises at L+k(H+W), lasts H cycles, done
// at L+P*H+(P-1)*W), evaluated per cycle offset from the accepting edge.
module tb_ex_fsm_stim_gen;

  localparam int CNT_W   = 8;
  localparam int PULSE_W = 8;

  logic               sclk;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   lead_len;
  logic [CNT_W-1:0]   high_len;
  logic [CNT_W-1:0]   low_len;
  logic [PULSE_W-1:0] pulses;
  logic               A;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  ex_fsm_stim_gen #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .start    (start),
    .lead_len (lead_len),
    .high_len (high_len),
    .low_len  (low_len),
    .pulses   (pulses),
    .A        (A),
    .busy     (busy),
    .done     (done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Offset (in edges after the accept edge) of the completion edge.
  function automatic int end_time(int l, int h, int w, int p);
    int he, we;
    he = (h < 1) ? 1 : h;
    we = (w < 1) ? 1 : w;
    if (p == 0) return 1;
    return l + p * he + (p - 1) * we;
  endfunction

  // Expected {A,busy,done} in the cycle following edge N+t.
  function automatic logic [2:0] exp_out(int l, int h, int w, int p, int t);
    int he, we, e;
    he = (h < 1) ? 1 : h;
    we = (w < 1) ? 1 : w;
    e  = end_time(l, h, w, p);
    if (t < 0 || t > e) return 3'b000;
    if (t == e) return 3'b001;
    if (p > 0 && t >= l && ((t - l) % (he + we)) < he) return 3'b110;
    return 3'b010;
  endfunction

  task automatic set_cfg(int l, int h, int w, int p);
    lead_len = CNT_W'(l);
    high_len = CNT_W'(h);
    low_len  = CNT_W'(w);
    pulses   = PULSE_W'(p);
  endtask

  task automatic scramble_cfg();
    lead_len = CNT_W'($urandom);
    high_len = CNT_W'($urandom);
    low_len  = CNT_W'($urandom);
    pulses   = PULSE_W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    set_cfg(0, 0, 0, 0);
    #1;
    checks++;
    if ({A, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold got A/busy/done=%b required=000", {A, busy, done});
    end
    #99 rst = 1'b0;
    @(posedge sclk); #1;
    for (int t = 0; t < 50; t++) begin
      checks++;
      if ({A, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle t=%0d got A/busy/done=%b required=000", t, {A, busy, done});
      end
      @(posedge sclk); #1;
    end
    $display("test_reset: 51 cycles checked");
  endtask

  // Single run with a fixed configuration; config scrambled mid-run.
  task automatic run_fixed(string tag, int l, int h, int w, int p);
    int e;
    logic [2:0] exp;
    e = end_time(l, h, w, p);
    set_cfg(l, h, w, p);
    start = 1'b1;
    @(posedge sclk); #1;
    start = 1'b0;
    for (int t = 0; t <= e + 2; t++) begin
      exp = exp_out(l, h, w, p, t);
      checks++;
      if ({A, busy, done} !== exp) begin
        errors++;
        $display("FAIL %s t=%0d got A/busy/done=%b required=%b", tag, t, {A, busy, done}, exp);
      end
      if (t == 1) scramble_cfg();
      @(posedge sclk); #1;
    end
    $display("%s: L=%0d H=%0d W=%0d P=%0d done at N+%0d", tag, l, h, w, p, e);
  endtask

  task automatic test_reference();
    run_fixed("reference", 50, 250, 200, 2);
  endtask

  task automatic test_zero_len();
    run_fixed("zero_len", 0, 0, 0, 3);
  endtask

  task automatic test_empty();
    run_fixed("empty", 37, 4, 4, 0);
  endtask

  task automatic test_max_segment();
    run_fixed("max_lead_high", 255, 255, 1, 2);
    run_fixed("max_pulses", 1, 0, 0, 255);
  endtask

  // start held high: the done edge must not accept; next edge does.
  task automatic test_back_to_back();
    logic [2:0] exp;
    set_cfg(2, 3, 1, 1);
    start = 1'b1;
    @(posedge sclk); #1;
    for (int t = 0; t <= 13; t++) begin
      exp = (t <= 5) ? exp_out(2, 3, 1, 1, t) : exp_out(2, 3, 1, 1, t - 6);
      checks++;
      if ({A, busy, done} !== exp) begin
        errors++;
        $display("FAIL back_to_back t=%0d got A/busy/done=%b required=%b", t, {A, busy, done}, exp);
      end
      if (t == 1) scramble_cfg();
      if (t == 4) set_cfg(2, 3, 1, 1);
      if (t == 6) start = 1'b0;
      @(posedge sclk); #1;
    end
    $display("back_to_back: second accept expected at N+6");
  endtask

  // Random configs, random idle spacing, random start toggling while busy.
  task automatic test_random();
    int l, h, w, p, e;
    logic [2:0] exp;
    for (int i = 0; i < 25; i++) begin
      l = $urandom_range(0, 6);
      h = $urandom_range(0, 5);
      w = $urandom_range(0, 5);
      p = $urandom_range(0, 4);
      e = end_time(l, h, w, p);
      repeat ($urandom_range(0, 3)) begin
        @(posedge sclk); #1;
      end
      set_cfg(l, h, w, p);
      start = 1'b1;
      @(posedge sclk); #1;
      start = 1'b0;
      for (int t = 0; t <= e + 1; t++) begin
        exp = exp_out(l, h, w, p, t);
        checks++;
        if ({A, busy, done} !== exp) begin
          errors++;
          $display("FAIL random%0d t=%0d got A/busy/done=%b required=%b", i, t, {A, busy, done}, exp);
        end
        scramble_cfg();
        start = (t < e) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge sclk); #1;
      end
      $display("random%0d: L=%0d H=%0d W=%0d P=%0d done at N+%0d", i, l, h, w, p, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    set_cfg(50, 250, 200, 2);
    start = 1'b1;
    @(posedge sclk); #1;
    start = 1'b0;
    for (int t = 0; t < 100; t++) begin
      exp = exp_out(50, 250, 200, 2, t);
      checks++;
      if ({A, busy, done} !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre t=%0d got A/busy/done=%b required=%b", t, {A, busy, done}, exp);
      end
      @(posedge sclk); #1;
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({A, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async got A/busy/done=%b required=000", {A, busy, done});
    end
    @(posedge sclk);
    @(negedge sclk);
    rst = 1'b0;
    @(posedge sclk); #1;
    for (int t = 0; t < 10; t++) begin
      checks++;
      if ({A, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_quiet t=%0d got A/busy/done=%b required=000", t, {A, busy, done});
      end
      @(posedge sclk); #1;
    end
    $display("reset_mid: aborted during first HIGH, rerunning pattern");
    run_fixed("reset_mid_rerun", 50, 250, 200, 2);
  endtask

  initial begin
    test_reset();
    test_reference();
    test_zero_len();
    test_empty();
    test_back_to_back();
    test_max_segment();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
